// File: rtl/prefetch_controller.sv
// Instruction prefetch controller: single-outstanding memory fetch FSM feeding a small
// instruction queue, with redirect flush, response timeout and misaligned-target faults.
module prefetch_controller #(
    parameter int unsigned     XLEN     = 32,
    parameter int unsigned     DEPTH    = 4,
    parameter int unsigned     TIMEOUT  = 255,
    parameter logic [XLEN-1:0] RESET_PC = '0
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       redirect,
    input  logic [XLEN-1:0]            redirect_pc,
    input  logic                       memory_ready,
    input  logic                       memory_valid,
    input  logic [31:0]                memory_rdata,
    output logic                       memory_enable,
    output logic                       memory_command,
    output logic [XLEN-1:0]            memory_address,
    output logic                       instruction_valid,
    input  logic                       instruction_ready,
    output logic [31:0]                instruction,
    output logic [XLEN-1:0]            instruction_pc,
    output logic                       instruction_fault,
    output logic [$clog2(DEPTH+1)-1:0] count,
    output logic [1:0]                 debug_state
);

    localparam int unsigned PtrW = $clog2(DEPTH);
    localparam int unsigned CntW = $clog2(DEPTH + 1);
    localparam int unsigned TmoW = (TIMEOUT > 1) ? $clog2(TIMEOUT + 1) : 1;
    localparam logic [CntW-1:0] DepthC  = CntW'(DEPTH);
    localparam logic [TmoW-1:0] TmoLast = TmoW'((TIMEOUT == 0) ? 0 : TIMEOUT - 1);
    localparam bit TmoEn = (TIMEOUT != 0);

    typedef enum logic [1:0] {
        StFetch = 2'd0,
        StWait  = 2'd1,
        StDrain = 2'd2,
        StHalt  = 2'd3
    } state_e;

    state_e          state_q, state_d;
    logic [XLEN-1:0] fetch_pc_q, fetch_pc_d;
    logic [TmoW-1:0] wait_q, wait_d;

    logic [31:0]     data_q [DEPTH];
    logic [XLEN-1:0] pc_q [DEPTH];
    logic [DEPTH-1:0] fault_q;
    logic [PtrW-1:0] wr_ptr_q, rd_ptr_q;
    logic [CntW-1:0] count_q;

    logic            push, pop, push_fault, timeout_hit;
    logic [31:0]     push_data;
    logic [XLEN-1:0] push_pc;

    assign instruction_valid = (count_q != '0);
    assign pop               = instruction_valid & instruction_ready & ~redirect;
    // Timeout fires in the TIMEOUT-th consecutive cycle spent waiting without a response.
    assign timeout_hit       = TmoEn && !memory_valid && (wait_q == TmoLast);

    always_comb begin
        state_d       = state_q;
        fetch_pc_d    = fetch_pc_q;
        wait_d        = wait_q;
        push          = 1'b0;
        push_fault    = 1'b0;
        push_data     = '0;
        push_pc       = fetch_pc_q;
        memory_enable = 1'b0;

        if (redirect) begin
            fetch_pc_d = redirect_pc;
            wait_d     = '0;
            // A request still in flight must have its response swallowed before refetching.
            if ((state_q == StWait || state_q == StDrain) && !memory_valid) begin
                state_d = StDrain;
            end else begin
                state_d = StFetch;
            end
        end else begin
            unique case (state_q)
                StFetch: begin
                    if (fetch_pc_q[1:0] != 2'b00) begin
                        push       = 1'b1;
                        push_fault = 1'b1;
                        state_d    = StHalt;
                    end else if (reset && memory_ready && (count_q < DepthC)) begin
                        memory_enable = 1'b1;
                        state_d       = StWait;
                    end
                end
                StWait: begin
                    if (memory_valid) begin
                        push       = 1'b1;
                        push_data  = memory_rdata;
                        fetch_pc_d = fetch_pc_q + XLEN'(4);
                        wait_d     = '0;
                        state_d    = StFetch;
                    end else if (timeout_hit) begin
                        push       = 1'b1;
                        push_fault = 1'b1;
                        wait_d     = '0;
                        state_d    = StHalt;
                    end else if (TmoEn) begin
                        wait_d = wait_q + TmoW'(1);
                    end
                end
                StDrain: begin
                    if (memory_valid || timeout_hit) begin
                        wait_d  = '0;
                        state_d = StFetch;
                    end else if (TmoEn) begin
                        wait_d = wait_q + TmoW'(1);
                    end
                end
                StHalt: begin
                end
                default: state_d = StFetch;
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q    <= StFetch;
            fetch_pc_q <= RESET_PC;
            wait_q     <= '0;
        end else begin
            state_q    <= state_d;
            fetch_pc_q <= fetch_pc_d;
            wait_q     <= wait_d;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else if (redirect) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (push) wr_ptr_q <= wr_ptr_q + PtrW'(1);
            if (pop)  rd_ptr_q <= rd_ptr_q + PtrW'(1);
            if (push && !pop) begin
                count_q <= count_q + CntW'(1);
            end else if (!push && pop) begin
                count_q <= count_q - CntW'(1);
            end
        end
    end

    // Storage needs no reset: head outputs are masked whenever the queue is empty.
    always_ff @(posedge clk) begin
        if (push) begin
            data_q[wr_ptr_q]  <= push_data;
            pc_q[wr_ptr_q]    <= push_pc;
            fault_q[wr_ptr_q] <= push_fault;
        end
    end

    assign memory_command    = 1'b0;
    assign memory_address    = fetch_pc_q;
    assign instruction       = instruction_valid ? data_q[rd_ptr_q] : '0;
    assign instruction_pc    = instruction_valid ? pc_q[rd_ptr_q] : '0;
    assign instruction_fault = instruction_valid & fault_q[rd_ptr_q];
    assign count             = count_q;
    assign debug_state       = state_q;

endmodule

// File: tb/tb_prefetch_controller.sv
// Bench for prefetch_controller: cycle table for fetch/backpressure plus hand sequences for
// redirect drain, timeout, misaligned redirect and reset; queue output checked by scoreboard.
module tb_prefetch_controller;

    logic        clk = 1'b0;
    logic        reset, redirect, memory_ready, memory_valid, instruction_ready;
    logic [31:0] redirect_pc, memory_rdata;
    logic        memory_enable, memory_command, instruction_valid, instruction_fault;
    logic [31:0] memory_address, instruction, instruction_pc;
    logic [2:0]  count_w;
    logic [1:0]  debug_state;

    prefetch_controller #(
        .XLEN     (32),
        .DEPTH    (4),
        .TIMEOUT  (8),
        .RESET_PC (32'h0)
    ) dut (
        .clk               (clk),
        .reset             (reset),
        .redirect          (redirect),
        .redirect_pc       (redirect_pc),
        .memory_ready      (memory_ready),
        .memory_valid      (memory_valid),
        .memory_rdata      (memory_rdata),
        .memory_enable     (memory_enable),
        .memory_command    (memory_command),
        .memory_address    (memory_address),
        .instruction_valid (instruction_valid),
        .instruction_ready (instruction_ready),
        .instruction       (instruction),
        .instruction_pc    (instruction_pc),
        .instruction_fault (instruction_fault),
        .count             (count_w),
        .debug_state       (debug_state)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] instr;
        logic [31:0] pc;
        logic        fault;
    } ent_t;

    typedef struct {
        logic        rst_n;
        logic        mrdy;
        logic        irdy;
        logic        exp_en;
        logic [31:0] exp_addr;
        int          exp_cnt;
        int          exp_st;
        logic        exp_iv;
    } vec_t;

    ent_t exp_q[$];
    ent_t ent;
    vec_t vecs[$];
    int   checks = 0;
    int   errors = 0;
    int   en_seen;

    // Memory model: one pending request answered mem_lat cycles after issue (if mem_on).
    logic        mem_pend, mem_stale;
    int          mem_left, mem_lat;
    logic        mem_on;
    logic [31:0] mem_addr;

    logic        s_en, s_iv, s_fault;
    logic [31:0] s_addr, s_cnt, s_st, s_pc, s_instr;

    function automatic vec_t mk(logic rst_n, logic mrdy, logic irdy, logic exp_en,
                                logic [31:0] exp_addr, int exp_cnt, int exp_st, logic exp_iv);
        vec_t v;
        v.rst_n = rst_n; v.mrdy = mrdy; v.irdy = irdy; v.exp_en = exp_en;
        v.exp_addr = exp_addr; v.exp_cnt = exp_cnt; v.exp_st = exp_st; v.exp_iv = exp_iv;
        return v;
    endfunction

    function automatic logic [31:0] word_of(logic [31:0] a);
        if (a == 32'h0) return 32'h13;
        if (a == 32'h4) return 32'h93;
        return {a[23:0], 8'h13};
    endfunction

    task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // One clock cycle: entered and left at a falling edge with inputs already applied.
    task automatic tick();
        memory_valid = 1'b0;
        memory_rdata = '0;
        if (mem_pend && mem_on) begin
            mem_left--;
            if (mem_left <= 0) begin
                memory_valid = 1'b1;
                memory_rdata = word_of(mem_addr);
            end
        end
        #1;
        s_en = memory_enable; s_addr = memory_address; s_cnt = 32'(count_w);
        s_st = 32'(debug_state); s_iv = instruction_valid; s_fault = instruction_fault;
        s_pc = instruction_pc; s_instr = instruction;
        if (reset) begin
            if (redirect) begin
                exp_q.delete();
                if (mem_pend) mem_stale = 1'b1;
            end else begin
                if (instruction_valid && instruction_ready) begin
                    if (exp_q.size() == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL sb_unexpected_pop: got pc %h expected no entry",
                                 instruction_pc);
                    end else begin
                        ent = exp_q.pop_front();
                        chk("sb_instr", instruction, ent.instr);
                        chk("sb_pc", instruction_pc, ent.pc);
                        chk("sb_fault", 32'(instruction_fault), 32'(ent.fault));
                    end
                end
                if (memory_valid && !mem_stale) begin
                    exp_q.push_back('{word_of(mem_addr), mem_addr, 1'b0});
                end
            end
            if (memory_valid) mem_pend = 1'b0;
            if (memory_enable && memory_ready) begin
                mem_pend  = 1'b1;
                mem_stale = 1'b0;
                mem_left  = mem_lat;
                mem_addr  = memory_address;
            end
        end else begin
            mem_pend = 1'b0;
            exp_q.delete();
        end
        @(posedge clk);
        @(negedge clk);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got no finish expected finish");
        $fatal(1);
    end

    initial begin
        reset = 1'b0; redirect = 1'b0; redirect_pc = '0; memory_ready = 1'b0;
        memory_valid = 1'b0; memory_rdata = '0; instruction_ready = 1'b0;
        mem_pend = 1'b0; mem_stale = 1'b0; mem_left = 0; mem_addr = '0;
        mem_lat = 1; mem_on = 1'b1;

        // rst_n, mrdy, irdy | en, addr, count, state, ivalid
        vecs.push_back(mk(0, 0, 0, 0, 32'h00, 0, 0, 0));
        vecs.push_back(mk(0, 1, 1, 0, 32'h00, 0, 0, 0));
        vecs.push_back(mk(1, 1, 1, 1, 32'h00, 0, 0, 0));
        vecs.push_back(mk(1, 1, 1, 0, 32'h00, 0, 1, 0));
        vecs.push_back(mk(1, 1, 1, 1, 32'h04, 1, 0, 1));
        vecs.push_back(mk(1, 1, 1, 0, 32'h00, 0, 1, 0));
        vecs.push_back(mk(1, 1, 1, 1, 32'h08, 1, 0, 1));
        vecs.push_back(mk(1, 1, 1, 0, 32'h00, 0, 1, 0));
        vecs.push_back(mk(0, 1, 0, 0, 32'h00, 0, 0, 0));
        vecs.push_back(mk(1, 1, 0, 1, 32'h00, 0, 0, 0));
        vecs.push_back(mk(1, 1, 0, 0, 32'h00, 0, 1, 0));
        vecs.push_back(mk(1, 1, 0, 1, 32'h04, 1, 0, 1));
        vecs.push_back(mk(1, 1, 0, 0, 32'h00, 1, 1, 1));
        vecs.push_back(mk(1, 1, 0, 1, 32'h08, 2, 0, 1));
        vecs.push_back(mk(1, 1, 0, 0, 32'h00, 2, 1, 1));
        vecs.push_back(mk(1, 1, 0, 1, 32'h0C, 3, 0, 1));
        vecs.push_back(mk(1, 1, 0, 0, 32'h00, 3, 1, 1));
        vecs.push_back(mk(1, 1, 0, 0, 32'h00, 4, 0, 1));
        vecs.push_back(mk(1, 1, 0, 0, 32'h00, 4, 0, 1));
        vecs.push_back(mk(1, 1, 1, 0, 32'h00, 4, 0, 1));
        vecs.push_back(mk(1, 1, 0, 1, 32'h10, 3, 0, 1));
        vecs.push_back(mk(1, 1, 1, 0, 32'h00, 3, 1, 1));
        vecs.push_back(mk(1, 1, 0, 1, 32'h14, 3, 0, 1));
        vecs.push_back(mk(1, 1, 0, 0, 32'h00, 3, 1, 1));
        vecs.push_back(mk(1, 1, 0, 0, 32'h00, 4, 0, 1));
        vecs.push_back(mk(1, 0, 1, 0, 32'h00, 4, 0, 1));
        vecs.push_back(mk(1, 0, 1, 0, 32'h00, 3, 0, 1));
        vecs.push_back(mk(1, 0, 1, 0, 32'h00, 2, 0, 1));
        vecs.push_back(mk(1, 0, 1, 0, 32'h00, 1, 0, 1));
        vecs.push_back(mk(1, 0, 1, 0, 32'h00, 0, 0, 0));

        @(negedge clk);
        for (int i = 0; i < vecs.size(); i++) begin
            reset = vecs[i].rst_n;
            memory_ready = vecs[i].mrdy;
            instruction_ready = vecs[i].irdy;
            tick();
            chk($sformatf("v%0d_en", i), 32'(s_en), 32'(vecs[i].exp_en));
            if (vecs[i].exp_en) chk($sformatf("v%0d_addr", i), s_addr, vecs[i].exp_addr);
            chk($sformatf("v%0d_count", i), s_cnt, vecs[i].exp_cnt);
            chk($sformatf("v%0d_state", i), s_st, vecs[i].exp_st);
            chk($sformatf("v%0d_ivalid", i), 32'(s_iv), 32'(vecs[i].exp_iv));
        end

        // Redirect while waiting: queue flushed, late response dropped in DRAIN.
        memory_ready = 1'b1; instruction_ready = 1'b0; mem_lat = 1;
        tick();
        chk("a_issue0_addr", s_addr, 32'h18);
        tick();
        mem_lat = 4;
        tick();
        chk("a_issue1_addr", s_addr, 32'h1C);
        chk("a_count_before", s_cnt, 1);
        redirect = 1'b1; redirect_pc = 32'h100;
        tick();
        chk("a_redir_state", s_st, 1);
        redirect = 1'b0;
        tick();
        chk("a_drain_state", s_st, 2);
        chk("a_flush_count", s_cnt, 0);
        chk("a_drain_noreq", 32'(s_en), 0);
        tick();
        tick();
        chk("a_drain_resp_state", s_st, 2);
        mem_lat = 1;
        tick();
        chk("a_refetch_en", 32'(s_en), 1);
        chk("a_refetch_addr", s_addr, 32'h100);
        tick();
        memory_ready = 1'b0; instruction_ready = 1'b1;
        tick();
        chk("a_count_new", s_cnt, 1);
        tick();

        // Timeout: fault entry in the 8th waiting cycle, then HALT with no requests.
        memory_ready = 1'b1; instruction_ready = 1'b0; mem_on = 1'b0;
        tick();
        chk("b_issue_addr", s_addr, 32'h104);
        en_seen = 0;
        for (int k = 1; k <= 8; k++) begin
            tick();
            en_seen += 32'(s_en);
            if (k == 8) begin
                chk("b_wait8_state", s_st, 1);
                chk("b_wait8_count", s_cnt, 0);
            end
        end
        chk("b_wait_noreq", en_seen, 0);
        tick();
        chk("b_halt_state", s_st, 3);
        chk("b_fault_count", s_cnt, 1);
        chk("b_fault_flag", 32'(s_fault), 1);
        chk("b_fault_pc", s_pc, 32'h104);
        chk("b_fault_instr", s_instr, 0);
        exp_q.push_back('{32'h0, 32'h104, 1'b1});
        mem_pend = 1'b0; mem_on = 1'b1;
        en_seen = 0;
        repeat (4) begin
            tick();
            en_seen += 32'(s_en);
        end
        chk("b_halt_noreq", en_seen, 0);
        chk("b_halt_stay", s_st, 3);
        instruction_ready = 1'b1;
        tick();
        instruction_ready = 1'b0;
        tick();
        chk("b_fault_popped", s_cnt, 0);

        // Misaligned redirect target: no fetch, fault entry, HALT.
        redirect = 1'b1; redirect_pc = 32'h102;
        tick();
        redirect = 1'b0;
        tick();
        chk("c_fetch_state", s_st, 0);
        chk("c_noreq", 32'(s_en), 0);
        exp_q.push_back('{32'h0, 32'h102, 1'b1});
        tick();
        chk("c_halt_state", s_st, 3);
        chk("c_fault_flag", 32'(s_fault), 1);
        chk("c_fault_pc", s_pc, 32'h102);
        chk("c_fault_instr", s_instr, 0);
        instruction_ready = 1'b1;
        tick();
        instruction_ready = 1'b0;
        en_seen = 0;
        repeat (3) begin
            tick();
            en_seen += 32'(s_en);
        end
        chk("c_halt_noreq", en_seen, 0);
        redirect = 1'b1; redirect_pc = 32'h200;
        tick();
        redirect = 1'b0;
        tick();
        chk("c_resume_en", 32'(s_en), 1);
        chk("c_resume_addr", s_addr, 32'h200);

        // Reset in the middle of a wait abandons the request and restarts at RESET_PC.
        mem_on = 1'b0;
        tick();
        chk("d_wait_state", s_st, 1);
        reset = 1'b0;
        tick();
        chk("d_rst_state", s_st, 0);
        chk("d_rst_en", 32'(s_en), 0);
        chk("d_rst_iv", 32'(s_iv), 0);
        reset = 1'b1; memory_ready = 1'b0; mem_on = 1'b1;
        tick();
        chk("d_idle_en", 32'(s_en), 0);
        memory_ready = 1'b1;
        tick();
        chk("d_first_en", 32'(s_en), 1);
        chk("d_first_addr", s_addr, 32'h0);
        tick();
        memory_ready = 1'b0; instruction_ready = 1'b1;
        tick();
        chk("sb_empty", exp_q.size(), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
